// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side buffer between the UART receiver and the register interface.
// Each completed frame becomes a 9-bit entry {err, data} in a first-word-fall-through FIFO.
//
// Ports:
//   clk, rst            - system clock, asynchronous active-high reset
//   rx_valid_i          - one-cycle pulse: good frame on rx_data_i
//   rx_parity_error_i   - parity-error level from receiver (rising edge = one error frame)
//   rx_data_i           - received byte
//   rd_en_i             - pop head entry (ignored when empty)
//   flush_i             - synchronous flush of FIFO contents
//   clr_status_i        - clears overrun_o and err_cnt_o
//   threshold_i         - level-interrupt threshold, 0 disables
//   rd_data_o, rd_err_o - head entry (valid while !empty_o)
//   empty_o, full_o     - occupancy flags
//   count_o             - occupancy 0..DEPTH
//   overrun_o           - sticky: a frame was dropped because the FIFO was full
//   err_cnt_o           - saturating count of parity-failed frames
//   level_irq_o         - registered: threshold_i != 0 && count_o >= threshold_i
module uart_rx_fifo #(
  parameter int unsigned ADDR_W       = 4,
  parameter bit          DROP_ERRORED = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid_i,
  input  logic              rx_parity_error_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rd_en_i,
  input  logic              flush_i,
  input  logic              clr_status_i,
  input  logic [ADDR_W:0]   threshold_i,
  output logic [7:0]        rd_data_o,
  output logic              rd_err_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overrun_o,
  output logic [7:0]        err_cnt_o,
  output logic              level_irq_o
);

  localparam int unsigned     DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

  logic [8:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_perr;
  logic              r_overrun;
  logic [7:0]        r_err_cnt;
  logic              r_level_irq;

  logic              w_empty, w_full;
  logic              w_err_evt, w_push_req, w_push, w_pop, w_ovr_evt;
  logic [8:0]        w_entry;
  logic [ADDR_W:0]   w_count_d;
  logic              w_irq_d;
  logic              w_overrun_d;
  logic [7:0]        w_err_cnt_d;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);

  // Parity error is a level held until the next start bit; only its rising edge is a frame.
  assign w_err_evt  = rx_parity_error_i & ~r_perr;
  assign w_push_req = rx_valid_i | (w_err_evt & ~DROP_ERRORED);
  // A good frame wins over a coincident error edge.
  assign w_entry    = {~rx_valid_i, rx_data_i};

  assign w_pop     = rd_en_i & ~w_empty & ~flush_i;
  // When full, a simultaneous pop frees the slot being written.
  assign w_push    = w_push_req & (~w_full | w_pop) & ~flush_i;
  assign w_ovr_evt = w_push_req & w_full & ~rd_en_i & ~flush_i;

  always_comb begin
    w_count_d = r_count;
    if (flush_i) begin
      w_count_d = '0;
    end else if (w_push && !w_pop) begin
      w_count_d = r_count + ONE_C;
    end else if (w_pop && !w_push) begin
      w_count_d = r_count - ONE_C;
    end
  end

  assign w_irq_d = (threshold_i != '0) && (w_count_d >= threshold_i);

  always_comb begin
    w_overrun_d = r_overrun;
    if (w_ovr_evt) begin
      w_overrun_d = 1'b1;
    end else if (clr_status_i) begin
      w_overrun_d = 1'b0;
    end
  end

  always_comb begin
    w_err_cnt_d = r_err_cnt;
    if (w_err_evt) begin
      if (clr_status_i) begin
        w_err_cnt_d = 8'd1;
      end else if (r_err_cnt != 8'hFF) begin
        w_err_cnt_d = r_err_cnt + 8'd1;
      end
    end else if (clr_status_i) begin
      w_err_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_perr      <= 1'b0;
      r_overrun   <= 1'b0;
      r_err_cnt   <= 8'd0;
      r_level_irq <= 1'b0;
    end else begin
      r_perr      <= rx_parity_error_i;
      r_count     <= w_count_d;
      r_overrun   <= w_overrun_d;
      r_err_cnt   <= w_err_cnt_d;
      r_level_irq <= w_irq_d;
      if (flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
    end
  end

  // Storage is not reset; the head is masked while empty so outputs read 0 out of reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  assign rd_data_o   = w_empty ? 8'd0 : r_mem[r_rd_ptr][7:0];
  assign rd_err_o    = w_empty ? 1'b0 : r_mem[r_rd_ptr][8];
  assign empty_o     = w_empty;
  assign full_o      = w_full;
  assign count_o     = r_count;
  assign overrun_o   = r_overrun;
  assign err_cnt_o   = r_err_cnt;
  assign level_irq_o = r_level_irq;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid_i, rx_parity_error_i, rd_en_i, flush_i, clr_status_i;
  logic [7:0] rx_data_i;
  logic [4:0] threshold_i;

  logic [7:0] rd_data_o, err_cnt_o;
  logic       rd_err_o, empty_o, full_o, overrun_o, level_irq_o;
  logic [4:0] count_o;

  logic [7:0] d_rd_data_o, d_err_cnt_o;
  logic       d_rd_err_o, d_empty_o, d_full_o, d_overrun_o, d_level_irq_o;
  logic [4:0] d_count_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.ADDR_W(4), .DROP_ERRORED(1'b0)) u_dut (
    .clk(clk), .rst(rst), .rx_valid_i(rx_valid_i), .rx_parity_error_i(rx_parity_error_i),
    .rx_data_i(rx_data_i), .rd_en_i(rd_en_i), .flush_i(flush_i), .clr_status_i(clr_status_i),
    .threshold_i(threshold_i), .rd_data_o(rd_data_o), .rd_err_o(rd_err_o), .empty_o(empty_o),
    .full_o(full_o), .count_o(count_o), .overrun_o(overrun_o), .err_cnt_o(err_cnt_o),
    .level_irq_o(level_irq_o)
  );

  uart_rx_fifo #(.ADDR_W(4), .DROP_ERRORED(1'b1)) u_dut_drop (
    .clk(clk), .rst(rst), .rx_valid_i(rx_valid_i), .rx_parity_error_i(rx_parity_error_i),
    .rx_data_i(rx_data_i), .rd_en_i(rd_en_i), .flush_i(flush_i), .clr_status_i(clr_status_i),
    .threshold_i(threshold_i), .rd_data_o(d_rd_data_o), .rd_err_o(d_rd_err_o),
    .empty_o(d_empty_o), .full_o(d_full_o), .count_o(d_count_o), .overrun_o(d_overrun_o),
    .err_cnt_o(d_err_cnt_o), .level_irq_o(d_level_irq_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    step();
    rx_valid_i = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, 32'(rd_data_o), 32'(exp));
    rd_en_i = 1'b1;
    step();
    rd_en_i = 1'b0;
  endtask

  logic [7:0] q[$];
  logic [7:0] v;

  initial begin
    rst = 1'b1; rx_valid_i = 0; rx_parity_error_i = 0; rd_en_i = 0; flush_i = 0;
    clr_status_i = 0; rx_data_i = 8'h00; threshold_i = 5'd0;
    step(); step();
    check("rst_count", 32'(count_o), 0);
    check("rst_empty", 32'(empty_o), 1);
    check("rst_full", 32'(full_o), 0);
    check("rst_overrun", 32'(overrun_o), 0);
    check("rst_errcnt", 32'(err_cnt_o), 0);
    check("rst_irq", 32'(level_irq_o), 0);
    check("rst_rddata", 32'(rd_data_o), 0);
    check("rst_rderr", 32'(rd_err_o), 0);
    rst = 1'b0;
    step();

    // Pop while empty has no effect.
    rd_en_i = 1'b1; step(); rd_en_i = 1'b0;
    check("empty_pop_count", 32'(count_o), 0);
    check("empty_pop_empty", 32'(empty_o), 1);

    // Three good frames, drained in order.
    push(8'h41); push(8'h42); push(8'h43);
    check("t1_count", 32'(count_o), 3);
    check("t1_head", 32'(rd_data_o), 32'h41);
    check("t1_err", 32'(rd_err_o), 0);
    pop_check("t1_pop0", 8'h41);
    pop_check("t1_pop1", 8'h42);
    pop_check("t1_pop2", 8'h43);
    check("t1_empty", 32'(empty_o), 1);

    // Parity error held high for 100 cycles: one entry, one count.
    rx_data_i = 8'h5A; rx_parity_error_i = 1'b1;
    repeat (100) step();
    rx_parity_error_i = 1'b0;
    step();
    check("t2_count", 32'(count_o), 1);
    check("t2_head", 32'(rd_data_o), 32'h5A);
    check("t2_err", 32'(rd_err_o), 1);
    check("t2_errcnt", 32'(err_cnt_o), 1);
    check("t2_drop_count", 32'(d_count_o), 0);
    check("t2_drop_errcnt", 32'(d_err_cnt_o), 1);
    pop_check("t2_pop", 8'h5A);
    check("t2_empty", 32'(empty_o), 1);

    // Fill, overrun, clear.
    for (int i = 0; i < 16; i++) push(8'(i));
    check("t3_full", 32'(full_o), 1);
    check("t3_count", 32'(count_o), 16);
    check("t3_ovr_before", 32'(overrun_o), 0);
    push(8'hFF);
    check("t3_overrun", 32'(overrun_o), 1);
    check("t3_head", 32'(rd_data_o), 32'h00);
    check("t3_count_after", 32'(count_o), 16);
    clr_status_i = 1'b1; step(); clr_status_i = 1'b0;
    check("t3_clr_ovr", 32'(overrun_o), 0);
    check("t3_clr_errcnt", 32'(err_cnt_o), 0);

    // Push and pop together while full.
    rx_valid_i = 1'b1; rx_data_i = 8'hAA; rd_en_i = 1'b1;
    step();
    rx_valid_i = 1'b0; rd_en_i = 1'b0;
    check("t4_count", 32'(count_o), 16);
    check("t4_ovr", 32'(overrun_o), 0);
    for (int i = 1; i < 16; i++) pop_check("t4_drain", 8'(i));
    check("t4_last_aa", 32'(rd_data_o), 32'hAA);
    pop_check("t4_drain_aa", 8'hAA);
    check("t4_empty", 32'(empty_o), 1);

    // Several more full rounds to walk the pointers past the wrap point.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) begin
        v = 8'((r * 16 + i) ^ 8'h3C);
        q.push_back(v);
        push(v);
      end
      check("t4_wrap_full", 32'(full_o), 1);
      while (q.size() != 0) pop_check("t4_wrap", q.pop_front());
      check("t4_wrap_empty", 32'(empty_o), 1);
    end

    // Level interrupt.
    threshold_i = 5'd4;
    push(8'h01); push(8'h02); push(8'h03);
    check("t5_irq_at3", 32'(level_irq_o), 0);
    push(8'h04);
    check("t5_count4", 32'(count_o), 4);
    check("t5_irq_at4", 32'(level_irq_o), 1);
    rd_en_i = 1'b1; step(); rd_en_i = 1'b0;
    check("t5_irq_pop", 32'(level_irq_o), 0);
    threshold_i = 5'd0;
    push(8'h05); push(8'h06);
    check("t5_irq_dis", 32'(level_irq_o), 0);

    // Flush with a simultaneous push.
    flush_i = 1'b1; step(); flush_i = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h70 + 8'(i));
    check("t6_count5", 32'(count_o), 5);
    flush_i = 1'b1; rx_valid_i = 1'b1; rx_data_i = 8'h77;
    step();
    flush_i = 1'b0; rx_valid_i = 1'b0;
    check("t6_flush_count", 32'(count_o), 0);
    check("t6_flush_empty", 32'(empty_o), 1);

    // Asynchronous reset mid-stream, with status nonzero.
    push(8'h11); push(8'h22);
    rx_data_i = 8'h33; rx_parity_error_i = 1'b1; step(); rx_parity_error_i = 1'b0;
    threshold_i = 5'd1; step();
    check("t7_pre_errcnt", 32'(err_cnt_o), 1);
    check("t7_pre_irq", 32'(level_irq_o), 1);
    rst = 1'b1;
    #1;
    check("t7_rst_count", 32'(count_o), 0);
    check("t7_rst_empty", 32'(empty_o), 1);
    check("t7_rst_errcnt", 32'(err_cnt_o), 0);
    check("t7_rst_irq", 32'(level_irq_o), 0);
    check("t7_rst_rddata", 32'(rd_data_o), 0);
    step();
    rst = 1'b0; threshold_i = 5'd0;
    step();

    // Error counter saturation, then clear racing an error edge.
    for (int i = 0; i < 300; i++) begin
      rx_data_i = 8'(i);
      rx_parity_error_i = 1'b1; step();
      rx_parity_error_i = 1'b0; step();
    end
    check("t8_sat", 32'(err_cnt_o), 255);
    check("t8_ovr", 32'(overrun_o), 1);
    rx_parity_error_i = 1'b1; clr_status_i = 1'b1; rd_en_i = 1'b1;
    step();
    rx_parity_error_i = 1'b0; clr_status_i = 1'b0; rd_en_i = 1'b0;
    check("t8_clr_race", 32'(err_cnt_o), 1);
    check("t8_clr_ovr", 32'(overrun_o), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
